// File: rtl/clock_display_driver_pkg.sv
// Shared constants and BCD helpers for the clock display path.
// Combinational content only; no latency.
// No handshake; values are consumed as-is.
package clock_disp_pkg;

  // Active-high segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Scan order: rightmost digit first
  localparam logic [2:0] DIG_SEC_ONES = 3'd0;
  localparam logic [2:0] DIG_SEC_TENS = 3'd1;
  localparam logic [2:0] DIG_MIN_ONES = 3'd2;
  localparam logic [2:0] DIG_MIN_TENS = 3'd3;
  localparam logic [2:0] DIG_HR_ONES  = 3'd4;
  localparam logic [2:0] DIG_HR_TENS  = 3'd5;

  localparam logic [5:0] MAX_SEC = 6'd59;
  localparam logic [5:0] MAX_MIN = 6'd59;
  localparam logic [5:0] MAX_HR  = 6'd23;

  // Tens digit by compare chain; fields never exceed 63 so no divider is needed
  function automatic logic [3:0] bcd_tens(input logic [5:0] v);
    if (v >= 6'd60)      return 4'd6;
    else if (v >= 6'd50) return 4'd5;
    else if (v >= 6'd40) return 4'd4;
    else if (v >= 6'd30) return 4'd3;
    else if (v >= 6'd20) return 4'd2;
    else if (v >= 6'd10) return 4'd1;
    else                 return 4'd0;
  endfunction

  function automatic logic [3:0] bcd_ones(input logic [5:0] v);
    logic [5:0] r;
    r = v - (6'(bcd_tens(v)) * 6'd10);
    return r[3:0];
  endfunction

endpackage

// File: rtl/clock_display_driver_if.sv
// Time-in / display-out bundle between clock core, display driver and pins.
// Wires only; no latency.
// No backpressure; the driver samples time whenever it starts a frame.
interface clock_display_driver_if;
  logic [5:0] seconds;
  logic [5:0] minutes;
  logic [4:0] hours;
  logic [6:0] seg;
  logic       dp;
  logic [5:0] an;
  logic       frame_start;

  modport master (output seconds, minutes, hours,
                  input  seg, dp, an, frame_start);
  modport slave  (input  seconds, minutes, hours,
                  output seg, dp, an, frame_start);
endinterface

// File: rtl/clock_display_driver_seg7_encode.sv
// BCD digit to active-high seven-segment pattern with dash/blank override.
// Purely combinational.
// No handshake.
module seg7_encode (
  input  logic [3:0] bcd,
  input  logic       dash,
  input  logic       blank,
  output logic [6:0] seg
);
  import clock_disp_pkg::*;

  // Dash wins over blank so an invalid field is never hidden
  always_comb begin
    seg = SEG_DASH;
    if (dash) begin
      seg = SEG_DASH;
    end else if (blank) begin
      seg = SEG_BLANK;
    end else begin
      case (bcd)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_DASH;
      endcase
    end
  end
endmodule

// File: rtl/clock_display_driver.sv
// Snapshots HH:MM:SS once per frame and scans six multiplexed 7-seg digits.
// Outputs change on the same edge that consumes the advance strobe (1 cycle).
// No backpressure; free-running scan, inputs are sampled only at frame start.
module clock_display_driver #(
  parameter int REFRESH_DIV        = 50000,
  parameter int ACTIVE_LOW         = 1,
  parameter int BLANK_LEADING_ZERO = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  clock_display_driver_if.slave  bus
);
  import clock_disp_pkg::*;

  localparam logic [20:0] DIV_LAST = 21'(REFRESH_DIV - 1);
  localparam logic        INV      = (ACTIVE_LOW != 0);
  localparam logic        BLANK_EN = (BLANK_LEADING_ZERO != 0);

  logic [20:0] div_q;
  logic        running_q;
  logic [2:0]  idx_q, idx_d;
  logic [5:0]  sec_q, sec_d, min_q, min_d;
  logic [4:0]  hr_q, hr_d;
  logic        adv, new_frame;
  logic [3:0]  dig_bcd;
  logic        dig_dash, dig_blank;
  logic [6:0]  seg_raw;
  logic [6:0]  seg_q;
  logic        dp_q;
  logic [5:0]  an_q;
  logic        frame_start_q;

  // Next-state for scan index and snapshot; outputs are encoded from these
  // so the new digit appears on the very edge that takes the advance
  always_comb begin
    adv       = (div_q == DIV_LAST);
    new_frame = adv && (!running_q || (idx_q == DIG_HR_TENS));
    idx_d     = idx_q;
    if (adv && running_q)
      idx_d = (idx_q == DIG_HR_TENS) ? DIG_SEC_ONES : idx_q + 3'd1;
    sec_d = new_frame ? bus.seconds : sec_q;
    min_d = new_frame ? bus.minutes : min_q;
    hr_d  = new_frame ? bus.hours   : hr_q;
  end

  // Select the digit for the upcoming index; out-of-range fields show dashes
  always_comb begin
    dig_bcd   = 4'd0;
    dig_dash  = 1'b0;
    dig_blank = 1'b0;
    case (idx_d)
      DIG_SEC_ONES: begin dig_bcd = bcd_ones(sec_d); dig_dash = (sec_d > MAX_SEC); end
      DIG_SEC_TENS: begin dig_bcd = bcd_tens(sec_d); dig_dash = (sec_d > MAX_SEC); end
      DIG_MIN_ONES: begin dig_bcd = bcd_ones(min_d); dig_dash = (min_d > MAX_MIN); end
      DIG_MIN_TENS: begin dig_bcd = bcd_tens(min_d); dig_dash = (min_d > MAX_MIN); end
      DIG_HR_ONES:  begin dig_bcd = bcd_ones({1'b0, hr_d}); dig_dash = ({1'b0, hr_d} > MAX_HR); end
      DIG_HR_TENS: begin
        dig_bcd   = bcd_tens({1'b0, hr_d});
        dig_dash  = ({1'b0, hr_d} > MAX_HR);
        dig_blank = BLANK_EN && (dig_bcd == 4'd0);
      end
      default: dig_dash = 1'b1;
    endcase
  end

  seg7_encode u_seg7_encode (
    .bcd   (dig_bcd),
    .dash  (dig_dash),
    .blank (dig_blank),
    .seg   (seg_raw)
  );

  // Divider, scan index, snapshot and registered pin outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q         <= '0;
      running_q     <= 1'b0;
      idx_q         <= DIG_SEC_ONES;
      sec_q         <= '0;
      min_q         <= '0;
      hr_q          <= '0;
      seg_q         <= {7{INV}};
      dp_q          <= INV;
      an_q          <= {6{INV}};
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= adv ? 21'd0 : div_q + 21'd1;
      frame_start_q <= new_frame;
      if (adv) begin
        running_q <= 1'b1;
        idx_q     <= idx_d;
        sec_q     <= sec_d;
        min_q     <= min_d;
        hr_q      <= hr_d;
        seg_q     <= seg_raw ^ {7{INV}};
        dp_q      <= ((idx_d == DIG_MIN_ONES) || (idx_d == DIG_HR_ONES)) ^ INV;
        an_q      <= (6'd1 << idx_d) ^ {6{INV}};
      end
    end
  end

  assign bus.seg         = seg_q;
  assign bus.dp          = dp_q;
  assign bus.an          = an_q;
  assign bus.frame_start = frame_start_q;

endmodule

// File: doc/clock_display_driver.md
Name: clock_display_driver

Overview:
Consumer end of the digital clock's time outputs. Samples hours/minutes/seconds once per display frame, splits each field into BCD tens/ones, and time-multiplexes six seven-segment digits (HH.MM.SS) onto shared segment lines with one-hot digit enables. It sits between the clock core and board-level display pins.

Parameters:
REFRESH_DIV, 50000, clock cycles each digit stays enabled; legal range 1..2^20.
ACTIVE_LOW, 1, 1 = seg, dp and an are driven active-low; 0 = active-high.
BLANK_LEADING_ZERO, 0, 1 = hours-tens digit is blanked when it is 0.

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high
seconds  in  6  binary seconds, valid range 0..59
minutes  in  6  binary minutes, valid range 0..59
hours  in  5  binary hours, valid range 0..23
seg  out  7  segments {g,f,e,d,c,b,a}; registered
dp  out  1  decimal point; registered
an  out  6  one-hot digit enable; an[0] = seconds ones … an[5] = hours tens; registered
frame_start  out  1  one-cycle pulse when a new snapshot is taken

Behaviour:
- Reset: clk and rst as already decided, one clock, synchronous active-high reset. While rst is high and on the first cycle after it: an all inactive, seg all inactive, dp inactive, frame_start = 0. Divider = 0, digit index = 0, snapshot = 00:00:00.
- Divider: counts 0..REFRESH_DIV-1. At terminal count it wraps to 0 and raises an internal advance strobe. With REFRESH_DIV=1, advance occurs every cycle.
- Digit index: 0..5. It increments on advance and wraps 5->0.
- Snapshot: on the first advance after reset, and on every advance that wraps index 5->0, capture seconds/minutes/hours into snapshot registers. frame_start pulses high in that same cycle. Input changes at any other time are invisible until the next frame, so a frame is never torn.
- BCD split: tens = field/10 and ones = field mod 10, computed from the snapshot. The range is at most 59, so a compare chain is sufficient and no divider is needed.
- Out of range: seconds > 59, minutes > 59 or hours > 23 show both digits of that field as dash (g only). Other fields display normally. No error flag.
- Output latency: seg/an/dp reflect the new index exactly 1 cycle after the advance strobe. Digit i is enabled for exactly REFRESH_DIV consecutive cycles. Exactly one an bit is active at any time after the first advance. There is no overlap and no gap.
- dp is active on index 2 (minutes ones) and index 4 (hours ones); it is inactive otherwise.
- Blank: when BLANK_LEADING_ZERO=1 and hours tens = 0, the seg value for index 5 is all inactive. Its an bit still asserts so the scan timing is uniform.
- Segment codes (active-high, gfedcba), digits 0 to 9: 0 = 3F, 1 = 06, 2 = 5B, 3 = 4F, 4 = 66, 5 = 6D, 6 = 7D, 7 = 07, 8 = 7F, 9 = 6F. Dash = 40, blank = 00. When ACTIVE_LOW=1, seg, dp and an are bitwise inverted at the output register.
- Reset mid-scan: the reset state applies on the next edge. The scan restarts at index 0, and a fresh snapshot is taken on the first advance after reset.

Decomposition:
- Shared package clock_disp_pkg holds:
  - segment constants SEG_0..SEG_9, SEG_DASH, SEG_BLANK;
  - digit index constants DIG_SEC_ONES..DIG_HR_TENS;
  - field limits MAX_SEC = 59, MAX_MIN = 59, MAX_HR = 23.
- One sub-module is natural: seg7_encode, a combinational 4-bit BCD to 7-segment encoder with a dash/blank select. It is instantiated once on the muxed digit, and it is also reusable by future alarm/set-time displays.

Test Plan:
All scenarios use ACTIVE_LOW=0 and REFRESH_DIV=4 unless stated.
1. rst high for 3 cycles, inputs 12:34:56 -> during rst and 1 cycle after: an=00, seg=00, dp=0. First frame_start occurs 4 cycles after rst falls.
2. Inputs 12:34:56 held -> index order 0..5. (an,seg,dp) = (01,7D,0), (02,6D,0), (04,66,1), (08,4F,0), (10,5B,1), (20,06,0). Each holds 4 cycles, then the sequence repeats.
3. Inputs 07:00:09, BLANK_LEADING_ZERO=1 -> index 5 gives an=20, seg=00; index 4 gives seg=07, dp=1; index 0 gives seg=6F.
4. seconds=60, minutes=05, hours=23 -> indexes 0 and 1 show seg=40. Indexes 2..5 show 6D, 3F, 4F, 5B.
5. Change inputs from 12:34:56 to 01:02:03 while index=2 -> remaining digits of that frame still show 12:34. After the next frame_start, the display shows 01:02:03.
6. Assert rst for 1 cycle while index=3 mid-dwell, with ACTIVE_LOW=1 -> an=3F and seg=7F next cycle. The scan restarts at index 0 with a new frame_start 4 cycles after rst falls.
